// File: rtl/pulse_width_meter_pkg.sv
// rtl/pulse_width_meter_pkg.sv - shared state encoding and saturation helper for the pulse width meter
package pulse_width_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEAS = 2'd1,
        HOLD = 2'd2
    } state_e;

    // All-ones value of a width-bit counter; the measured count saturates here.
    function automatic logic [31:0] max_count(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/pulse_width_meter_if.sv
// rtl/pulse_width_meter_if.sv - pulse input, enable, result and handshake bundle of the pulse width meter
interface pulse_width_meter_if #(
    parameter int WIDTH = 9
);
    logic             En;
    logic             P_in;
    logic             Ack;
    logic [WIDTH-1:0] Count;
    logic             Valid;
    logic             Ovf;
    logic             Lost;
    logic             Busy;

    modport master (
        output En,
        output P_in,
        output Ack,
        input  Count,
        input  Valid,
        input  Ovf,
        input  Lost,
        input  Busy
    );

    modport slave (
        input  En,
        input  P_in,
        input  Ack,
        output Count,
        output Valid,
        output Ovf,
        output Lost,
        output Busy
    );
endinterface

// File: rtl/pulse_width_meter_sync_edge.sv
// rtl/pulse_width_meter_sync_edge.sv - synchronizer for the asynchronous pulse input with rise/fall detection
module pulse_width_meter_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Clr,
    input  logic p_i,
    output logic ps_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ps_d_q;
    logic [SYNC_STAGES:0]   primed_q;

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            sync_q   <= '0;
            ps_d_q   <= 1'b0;
            primed_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], p_i};
            ps_d_q   <= sync_q[SYNC_STAGES-1];
            primed_q <= {primed_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign ps_o = sync_q[SYNC_STAGES-1];

    // Until ps_d holds a real sample of P_in, a 0->1 step is only the reset
    // value being flushed, so a pulse already high at reset release is ignored.
    assign rise_o = primed_q[SYNC_STAGES] & ps_o & ~ps_d_q;
    assign fall_o = ~ps_o & ps_d_q;

endmodule

// File: rtl/pulse_width_meter.sv
// rtl/pulse_width_meter.sv - measures the high time of P_in in clock cycles and presents it with a valid/ack handshake
module pulse_width_meter
    import pulse_width_meter_pkg::*;
#(
    parameter int WIDTH       = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic                Clk,
    input  logic                Clr,
    pulse_width_meter_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(max_count(WIDTH));

    logic ps;
    logic rise;
    logic fall;

    pulse_width_meter_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .Clk    (Clk),
        .Clr    (Clr),
        .p_i    (bus.P_in),
        .ps_o   (ps),
        .rise_o (rise),
        .fall_o (fall)
    );

    state_e           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] count_q;
    logic             valid_q;
    logic             ovf_q;
    logic             lost_q;
    logic             busy_q;

    always_comb begin
        cnt_d = cnt_q;
        if (ps && (cnt_q != MAX_CNT)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            lost_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise && bus.En) begin
                        state_q <= MEAS;
                        cnt_q   <= WIDTH'(1);
                        busy_q  <= 1'b1;
                    end
                end
                MEAS: begin
                    // Dropping En wins over a coincident fall: the pulse is discarded.
                    if (!bus.En) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (fall) begin
                        state_q <= HOLD;
                        count_q <= cnt_q;
                        ovf_q   <= (cnt_q == MAX_CNT);
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                HOLD: begin
                    if (bus.Ack) begin
                        valid_q <= 1'b0;
                        lost_q  <= 1'b0;
                        if (rise && bus.En) begin
                            state_q <= MEAS;
                            cnt_q   <= WIDTH'(1);
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (rise) begin
                        lost_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Count = count_q;
    assign bus.Valid = valid_q;
    assign bus.Ovf   = ovf_q;
    assign bus.Lost  = lost_q;
    assign bus.Busy  = busy_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// tb/tb_pulse_width_meter.sv - self-checking bench for pulse_width_meter
module tb_pulse_width_meter;

    localparam int WIDTH = 9;
    localparam int SYNC  = 2;
    localparam int MAXC  = (1 << WIDTH) - 1;

    logic Clk = 1'b0;
    logic Clr = 1'b1;

    pulse_width_meter_if #(.WIDTH(WIDTH)) bus ();

    pulse_width_meter #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC)
    ) dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int len;
        int exp_count;
        bit exp_ovf;
    } vec_t;

    vec_t vecs[10];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Drive one aligned pulse of len cycles and wait for its result.
    task automatic measure(input string tag, input int len, input int exp_count, input bit exp_ovf);
        int lat;
        int busy_bad;
        busy_bad = 0;
        bus.P_in = 1'b1;
        for (int k = 1; k <= len; k++) begin
            tick();
            if (k >= SYNC + 1 && bus.Busy !== 1'b1) busy_bad++;
        end
        bus.P_in = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.Valid && lat < 40);
        chk({tag, " latency"}, lat, SYNC + 1);
        chk({tag, " count"}, bus.Count, exp_count);
        chk({tag, " ovf"}, bus.Ovf, exp_ovf);
        chk({tag, " busy_during"}, busy_bad, 0);
        chk({tag, " busy_after"}, bus.Busy, 0);
        chk({tag, " lost"}, bus.Lost, 0);
    endtask

    task automatic do_ack(input string tag, input int exp_count);
        bus.Ack = 1'b1;
        tick();
        bus.Ack = 1'b0;
        chk({tag, " ack valid"}, bus.Valid, 0);
        chk({tag, " ack lost"}, bus.Lost, 0);
        chk({tag, " ack count"}, bus.Count, exp_count);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int busy_seen;
        int len;
        int exp_c;
        bit exp_o;
        int prev;

        vecs[0] = '{1,   1,   1'b0};
        vecs[1] = '{2,   2,   1'b0};
        vecs[2] = '{3,   3,   1'b0};
        vecs[3] = '{17,  17,  1'b0};
        vecs[4] = '{255, 255, 1'b0};
        vecs[5] = '{256, 256, 1'b0};
        vecs[6] = '{510, 510, 1'b0};
        vecs[7] = '{511, 511, 1'b1};
        vecs[8] = '{512, 511, 1'b1};
        vecs[9] = '{600, 511, 1'b1};

        bus.En   = 1'b0;
        bus.P_in = 1'b0;
        bus.Ack  = 1'b0;
        repeat (3) tick();
        chk("reset count", bus.Count, 0);
        chk("reset valid", bus.Valid, 0);
        chk("reset ovf", bus.Ovf, 0);
        chk("reset lost", bus.Lost, 0);
        chk("reset busy", bus.Busy, 0);
        Clr = 1'b0;
        repeat (5) tick();
        chk("release busy", bus.Busy, 0);
        chk("release valid", bus.Valid, 0);

        bus.En = 1'b1;
        measure("basic", 5, 5, 1'b0);
        chk("basic valid", bus.Valid, 1);
        do_ack("basic", 5);
        repeat (3) tick();

        measure("sat", 600, MAXC, 1'b1);
        do_ack("sat", MAXC);
        repeat (3) tick();

        // Second pulse while a result is pending is dropped.
        measure("lost first", 5, 5, 1'b0);
        bus.P_in = 1'b1;
        repeat (3) tick();
        bus.P_in = 1'b0;
        repeat (6) tick();
        chk("lost flag", bus.Lost, 1);
        chk("lost valid", bus.Valid, 1);
        chk("lost count", bus.Count, 5);
        chk("lost busy", bus.Busy, 0);
        do_ack("lost", 5);
        repeat (3) tick();

        // Ack coincides with the rise of a new 4-cycle pulse.
        measure("simul first", 5, 5, 1'b0);
        bus.P_in = 1'b1;
        tick();
        tick();
        bus.Ack = 1'b1;
        tick();
        bus.Ack = 1'b0;
        chk("simul valid drop", bus.Valid, 0);
        chk("simul busy", bus.Busy, 1);
        tick();
        bus.P_in = 1'b0;
        len = 0;
        do begin
            tick();
            len++;
        end while (!bus.Valid && len < 40);
        chk("simul latency", len, SYNC + 1);
        chk("simul count", bus.Count, 4);
        chk("simul lost", bus.Lost, 0);
        do_ack("simul", 4);
        repeat (3) tick();

        // En dropped mid-pulse aborts without a result.
        bus.P_in = 1'b1;
        repeat (3) tick();
        chk("abort busy before", bus.Busy, 1);
        bus.En = 1'b0;
        tick();
        chk("abort busy after", bus.Busy, 0);
        repeat (2) tick();
        bus.P_in = 1'b0;
        repeat (6) tick();
        chk("abort valid", bus.Valid, 0);
        chk("abort count", bus.Count, 4);
        bus.En = 1'b1;
        repeat (3) tick();

        // Asynchronous Clr mid-pulse, released with P_in still high.
        bus.P_in = 1'b1;
        repeat (3) tick();
        #2;
        Clr = 1'b1;
        #1;
        chk("clr count", bus.Count, 0);
        chk("clr busy", bus.Busy, 0);
        chk("clr valid", bus.Valid, 0);
        chk("clr ovf", bus.Ovf, 0);
        tick();
        Clr = 1'b0;
        busy_seen = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.Busy) busy_seen++;
        end
        bus.P_in = 1'b0;
        repeat (6) tick();
        chk("clr no meas busy", busy_seen, 0);
        chk("clr no meas valid", bus.Valid, 0);
        measure("clr one", 1, 1, 1'b0);
        do_ack("clr one", 1);
        repeat (3) tick();

        for (int i = 0; i < 10; i++) begin
            measure($sformatf("vec%0d", i), vecs[i].len, vecs[i].exp_count, vecs[i].exp_ovf);
            do_ack($sformatf("vec%0d", i), vecs[i].exp_count);
            repeat (2) tick();
        end

        // Random pulse train against a pulse-level reference.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 7) == 0) len = $urandom_range(505, 530);
            else len = $urandom_range(1, 40);
            exp_c = (len > MAXC) ? MAXC : len;
            exp_o = (len >= MAXC);
            measure($sformatf("rnd%0d", it), len, exp_c, exp_o);
            repeat ($urandom_range(0, 4)) tick();
            chk($sformatf("rnd%0d hold count", it), bus.Count, exp_c);
            if ($urandom_range(0, 3) == 0) begin
                prev = exp_c;
                bus.P_in = 1'b1;
                repeat ($urandom_range(1, 5)) tick();
                bus.P_in = 1'b0;
                repeat (6) tick();
                chk($sformatf("rnd%0d drop lost", it), bus.Lost, 1);
                chk($sformatf("rnd%0d drop count", it), bus.Count, prev);
            end
            do_ack($sformatf("rnd%0d", it), exp_c);
            repeat ($urandom_range(1, 5)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
